// File: rtl/multi_mode_water_lights.sv
`default_nettype none
// ============================================================================
// Module   : multi_mode_water_lights
// Brief    : N-channel running-light engine. It supports four step rates,
//            four pattern modes (rotate up, rotate down, bounce, fill bar)
//            and a synchronised, debounced run/pause push-button.
// Revision : 1.0 - initial release
// ============================================================================
module multi_mode_water_lights #(
  parameter int N_LEDS       = 8,
  parameter int DIV0         = 1000000,
  parameter int DIV1         = 10000000,
  parameter int DIV2         = 25000000,
  parameter int DIV3         = 50000000,
  parameter int DEBOUNCE_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,         // asynchronous assert, active-low
  input  logic              button,
  input  logic [1:0]        freq_set,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              running,
  output logic              step_pulse
);

  localparam int c_MAX01  = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int c_MAX23  = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int c_MAXDIV = (c_MAX01 > c_MAX23) ? c_MAX01 : c_MAX23;
  localparam int c_PW_RAW = $clog2(c_MAXDIV);
  localparam int c_PW     = (c_PW_RAW < 1) ? 1 : c_PW_RAW;
  localparam int c_DW_RAW = $clog2(DEBOUNCE_CYC);
  localparam int c_DW     = (c_DW_RAW < 1) ? 1 : c_DW_RAW;

  localparam logic [N_LEDS-1:0] c_LED_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic [c_DW-1:0]   r_dcnt;
  logic              w_accept;
  logic              w_rise;

  logic [1:0]        r_freq_q;
  logic [1:0]        r_mode_q;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_div_m1;
  logic              w_fchg;
  logic              w_mchg;
  logic              w_step;
  logic              r_running;
  logic              r_step_pulse;

  logic [N_LEDS-1:0] r_led;
  logic [N_LEDS-1:0] w_led_next;
  dir_t              r_dir;
  dir_t              w_dir_next;

  // The debounced level accepts the synchronised value once it has differed
  // for DEBOUNCE_CYC consecutive cycles. Only the rising acceptance toggles run.
  assign w_accept = (r_sync2 != r_deb) && (r_dcnt == c_DW'(DEBOUNCE_CYC - 1));
  assign w_rise   = w_accept && r_sync2;

  // Button synchroniser and debounce counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_dcnt <= '0;
      end else if (w_accept) begin
        r_deb  <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + c_DW'(1);
      end
    end
  end

  // Terminal count of the prescaler for the currently selected rate
  always_comb begin
    w_div_m1 = c_PW'(DIV0 - 1);
    case (freq_set)
      2'b00:   w_div_m1 = c_PW'(DIV0 - 1);
      2'b01:   w_div_m1 = c_PW'(DIV1 - 1);
      2'b10:   w_div_m1 = c_PW'(DIV2 - 1);
      default: w_div_m1 = c_PW'(DIV3 - 1);
    endcase
  end

  // A rate or mode change restarts the count and suppresses the step that edge
  assign w_fchg = (freq_set != r_freq_q);
  assign w_mchg = (mode != r_mode_q);
  assign w_step = r_running && !w_fchg && !w_mchg && (r_presc == w_div_m1);

  // Next pattern for each mode; applied only on a step edge
  always_comb begin
    w_led_next = r_led;
    w_dir_next = r_dir;
    case (mode)
      2'b00: w_led_next = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
      2'b01: w_led_next = {r_led[0], r_led[N_LEDS-1:1]};
      2'b10: begin
        // Turn around when an end is reached so each end is lit for one step
        if (r_dir == DIR_UP) begin
          if (r_led[N_LEDS-1]) begin
            w_led_next = r_led >> 1;
            w_dir_next = DIR_DOWN;
          end else begin
            w_led_next = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_next = r_led << 1;
            w_dir_next = DIR_UP;
          end else begin
            w_led_next = r_led >> 1;
          end
        end
      end
      default: begin
        if (&r_led) begin
          w_led_next = c_LED_INIT;
        end else begin
          w_led_next = {r_led[N_LEDS-2:0], 1'b1};
        end
      end
    endcase
  end

  // Run state, prescaler, step strobe and change-detect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_freq_q     <= 2'b00;
      r_mode_q     <= 2'b00;
      r_presc      <= '0;
      r_running    <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_freq_q     <= freq_set;
      r_mode_q     <= mode;
      r_step_pulse <= w_step;
      if (w_rise) begin
        r_running <= ~r_running;
      end
      // Cleared on any toggle so a resume always starts a full period
      if (w_mchg || w_fchg || !r_running || w_rise || w_step) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + c_PW'(1);
      end
    end
  end

  // LED pattern and bounce direction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= c_LED_INIT;
      r_dir <= DIR_UP;
    end else if (w_mchg) begin
      r_led <= c_LED_INIT;
      r_dir <= DIR_UP;
    end else if (w_step) begin
      r_led <= w_led_next;
      r_dir <= w_dir_next;
    end
  end

  assign led        = r_led;
  assign running    = r_running;
  assign step_pulse = r_step_pulse;

endmodule
`default_nettype wire

// File: tb/tb_multi_mode_water_lights.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_mode_water_lights
// Brief    : Directed self-checking bench for multi_mode_water_lights
//            (N_LEDS=8, DIV0..3 = 4/8/12/16, DEBOUNCE_CYC=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_mode_water_lights;

  logic       clk;
  logic       rst;
  logic       button;
  logic [1:0] freq_set;
  logic [1:0] mode;
  logic [7:0] led;
  logic       running;
  logic       step_pulse;

  int total = 0;
  int bad   = 0;

  multi_mode_water_lights #(
    .N_LEDS       (8),
    .DIV0         (4),
    .DIV1         (8),
    .DIV2         (12),
    .DIV3         (16),
    .DEBOUNCE_CYC (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .freq_set   (freq_set),
    .mode       (mode),
    .led        (led),
    .running    (running),
    .step_pulse (step_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rot_exp    [6]  = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_exp   [11] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'h01, 8'h03, 8'h07, 8'h0F};

  initial begin
    rst      = 1'b1;
    button   = 1'b0;
    freq_set = 2'b00;
    mode     = 2'b00;

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_led", led, 8'h01);
    chk("rst_running", running, 1'b0);
    chk("rst_step_pulse", step_pulse, 1'b0);
    step_clk(2);
    chk("rst_hold_led", led, 8'h01);

    // Release and press: first sampled at edge k, running rises at k+4
    rst    = 1'b1;
    button = 1'b1;
    step_clk(4);
    chk("deb_latency_early", running, 1'b0);
    step_clk(1);
    chk("deb_latency_run", running, 1'b1);
    chk("run_led_start", led, 8'h01);
    step_clk(3);
    chk("rot_before_first_step", led, 8'h01);
    chk("rot_no_pulse", step_pulse, 1'b0);
    step_clk(1);
    chk("rot_step1", led, 8'h02);
    chk("rot_pulse_high", step_pulse, 1'b1);
    step_clk(1);
    chk("rot_pulse_one_cycle", step_pulse, 1'b0);
    button = 1'b0;
    step_clk(3);
    chk("rot_step2", led, 8'h04);
    for (int i = 0; i < 6; i++) begin
      step_clk(4);
      chk($sformatf("rot_up_%0d", i), led, rot_exp[i]);
    end
    chk("release_no_toggle", running, 1'b1);

    // Two-cycle glitch must be ignored
    button = 1'b1;
    step_clk(2);
    button = 1'b0;
    step_clk(6);
    chk("glitch_running", running, 1'b1);
    chk("glitch_led", led, 8'h04);

    // Bounce mode: reload on the change edge, then 14-step period
    mode = 2'b10;
    step_clk(1);
    chk("bounce_reload", led, 8'h01);
    for (int i = 0; i < 15; i++) begin
      step_clk(4);
      chk($sformatf("bounce_%0d", i), led, bounce_exp[i]);
    end

    // Fill mode, wraps after all-ones
    mode = 2'b11;
    step_clk(1);
    chk("fill_reload", led, 8'h01);
    for (int i = 0; i < 11; i++) begin
      step_clk(4);
      chk($sformatf("fill_%0d", i), led, fill_exp[i]);
    end

    // Switch to rotate-down while led=0F
    mode = 2'b01;
    step_clk(1);
    chk("mode_switch_reload", led, 8'h01);
    step_clk(3);
    chk("down_before_step", led, 8'h01);
    step_clk(1);
    chk("down_step", led, 8'h80);

    // Rate change mid-count: next step exactly 8 cycles after change edge
    step_clk(2);
    freq_set = 2'b01;
    step_clk(8);
    chk("rate_before_step", led, 8'h80);
    step_clk(1);
    chk("rate_step", led, 8'h40);
    chk("rate_pulse", step_pulse, 1'b1);

    // Pause
    button = 1'b1;
    step_clk(4);
    chk("pause_early", running, 1'b1);
    step_clk(1);
    chk("pause_running", running, 1'b0);
    button = 1'b0;
    step_clk(50);
    chk("pause_frozen_led", led, 8'h40);
    chk("pause_still_off", running, 1'b0);

    // Resume: first step 8 cycles after running rises
    button = 1'b1;
    step_clk(4);
    chk("resume_early", running, 1'b0);
    step_clk(1);
    chk("resume_running", running, 1'b1);
    button = 1'b0;
    step_clk(7);
    chk("resume_before_step", led, 8'h40);
    step_clk(1);
    chk("resume_step", led, 8'h20);

    // Simultaneous mode and rate change: single clear, no step on that edge
    mode     = 2'b10;
    freq_set = 2'b00;
    step_clk(1);
    chk("dual_change_reload", led, 8'h01);
    step_clk(3);
    chk("dual_change_hold", led, 8'h01);
    step_clk(1);
    chk("dual_change_step", led, 8'h02);
    step_clk(24);
    chk("bounce2_top", led, 8'h80);
    step_clk(4);
    chk("bounce2_down", led, 8'h40);
    chk("bounce2_pulse", step_pulse, 1'b1);

    // Asynchronous reset between edges while bouncing downward
    #3 rst = 1'b0;
    #1;
    chk("async_rst_led", led, 8'h01);
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_pulse", step_pulse, 1'b0);
    step_clk(2);
    chk("async_rst_hold", led, 8'h01);

    // After release, bounce restarts upward
    rst    = 1'b1;
    button = 1'b1;
    step_clk(4);
    chk("rerun_early", running, 1'b0);
    step_clk(1);
    chk("rerun_running", running, 1'b1);
    button = 1'b0;
    step_clk(4);
    chk("rerun_up1", led, 8'h02);
    step_clk(4);
    chk("rerun_up2", led, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
